// File: rtl/aes_pkg.sv
// AES-128 shared constants: S-box, round constants, key-schedule states.
// Imported by the round-key generator and its SubWord unit.
package aes_pkg;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] RCON [10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   typedef enum logic [1:0] {
      IDLE,
      PRECOMP,
      EMIT
   } state_t;

   localparam int EMIT_DESC = 0;
   localparam int EMIT_ASC  = 1;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

endpackage

// File: rtl/aes_subword.sv
// AES SubWord: four parallel S-box lookups on a 32-bit word.
// Ports: w (word in), s (substituted word out). RotWord is the caller's job.
module aes_subword
   import aes_pkg::*;
(
   input  logic [31:0] w,
   output logic [31:0] s
);

   assign s = {sbox(w[31:24]), sbox(w[23:16]),
               sbox(w[15:8]),  sbox(w[7:0])};

endmodule

// File: rtl/aes128_inv_key_sched.sv
// Iterative AES-128 round-key generator, one 128-bit key register.
// Ports: clk, rst, flush; key_in/key_valid/key_ready in;
//        rk_out/rk_idx/rk_last/rk_valid/rk_ready out.
module aes128_inv_key_sched
   import aes_pkg::*;
#(
   parameter int EMIT_ORDER = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic [127:0] key_in,
   input  logic         key_valid,
   output logic         key_ready,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_idx,
   output logic         rk_last,
   output logic         rk_valid,
   input  logic         rk_ready
);

   localparam bit ASC = (EMIT_ORDER == EMIT_ASC);
   localparam logic [3:0] LAST_IDX = ASC ? 4'd10 : 4'd0;

   state_t       state;
   logic [127:0] key_r;
   logic [3:0]   cnt;

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rw1, rw2, rw3;
   logic [31:0] f0, f1, f2, f3, r0;
   logic [31:0] sw_in, sw_out, rc_word;
   logic [3:0]  rc_sel, rc_raw;
   logic        fwd;
   logic [127:0] next_key;

   assign {w0, w1, w2, w3} = key_r;

   // Reverse step recovers the previous words by undoing the xor chain.
   assign rw3 = w3 ^ w2;
   assign rw2 = w2 ^ w1;
   assign rw1 = w1 ^ w0;

   // Forward during precompute or in ascending order, reverse otherwise.
   assign fwd = (state == PRECOMP) || ASC;

   // Shared SubWord: old w3 going forward, freshly recovered w3 in reverse.
   assign sw_in = fwd ? {w3[23:0], w3[31:24]}
                      : {rw3[23:0], rw3[31:24]};

   aes_subword u_subword (
      .w (sw_in),
      .s (sw_out)
   );

   // Forward step into round r+1 uses Rcon[r]; reverse into r-1 uses Rcon[r-1].
   assign rc_raw  = fwd ? cnt : cnt - 4'd1;
   assign rc_sel  = (rc_raw > 4'd9) ? 4'd0 : rc_raw;
   assign rc_word = {RCON[rc_sel], 24'h0};

   assign f0 = w0 ^ sw_out ^ rc_word;
   assign f1 = w1 ^ f0;
   assign f2 = w2 ^ f1;
   assign f3 = w3 ^ f2;
   assign r0 = w0 ^ sw_out ^ rc_word;

   assign next_key = fwd ? {f0, f1, f2, f3}
                         : {r0, rw1, rw2, rw3};

   assign rk_out    = key_r;
   assign rk_idx    = cnt;
   assign rk_valid  = (state == EMIT);
   assign key_ready = (state == IDLE);
   assign rk_last   = (state == EMIT) && (cnt == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         key_r <= '0;
         cnt   <= '0;
      end else if (flush) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (key_valid) begin
                  key_r <= key_in;
                  cnt   <= '0;
                  state <= ASC ? EMIT : PRECOMP;
               end
            end
            PRECOMP: begin
               key_r <= next_key;
               cnt   <= cnt + 4'd1;
               if (cnt == 4'd9)
                  state <= EMIT;
            end
            EMIT: begin
               if (rk_ready) begin
                  if (rk_last) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else begin
                     key_r <= next_key;
                     cnt   <= ASC ? cnt + 4'd1 : cnt - 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_inv_key_sched.sv
// Scoreboard bench for aes128_inv_key_sched in both emission orders.
// Reference keys come from a textbook FIPS-197 expansion with a GF(2^8) S-box.
module tb_aes128_inv_key_sched;

   typedef struct packed {
      logic [127:0] k;
      logic [3:0]   idx;
      logic         last;
   } exp_t;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   logic         clk = 0;
   logic         rst = 1;
   logic         flush = 0;
   logic         rk_ready = 0;
   logic [127:0] key_in = '0;
   logic         key_valid [2];
   logic         key_ready [2];
   logic [127:0] rk_out [2];
   logic [3:0]   rk_idx [2];
   logic         rk_last [2];
   logic         rk_valid [2];

   int vectors = 0;
   int miscompares = 0;
   int hs [2];
   exp_t q0 [$];
   exp_t q1 [$];
   logic [7:0]   sb [256];
   logic [127:0] mk [11];

   always #5 clk = ~clk;

   aes128_inv_key_sched #(.EMIT_ORDER(0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush),
      .key_in(key_in), .key_valid(key_valid[0]), .key_ready(key_ready[0]),
      .rk_out(rk_out[0]), .rk_idx(rk_idx[0]), .rk_last(rk_last[0]),
      .rk_valid(rk_valid[0]), .rk_ready(rk_ready)
   );

   aes128_inv_key_sched #(.EMIT_ORDER(1)) dut1 (
      .clk(clk), .rst(rst), .flush(flush),
      .key_in(key_in), .key_valid(key_valid[1]), .key_ready(key_ready[1]),
      .rk_out(rk_out[1]), .rk_idx(rk_idx[1]), .rk_last(rk_last[1]),
      .rk_valid(rk_valid[1]), .rk_ready(rk_ready)
   );

   a_hold0: assert property (@(posedge clk) disable iff (rst)
      (rk_valid[0] && !rk_ready && !flush) |=>
      ($stable(rk_out[0]) && $stable(rk_idx[0]) && $stable(rk_last[0])))
      else $error("FAIL hold0: outputs changed while stalled");

   a_hold1: assert property (@(posedge clk) disable iff (rst)
      (rk_valid[1] && !rk_ready && !flush) |=>
      ($stable(rk_out[1]) && $stable(rk_idx[1]) && $stable(rk_last[1])))
      else $error("FAIL hold1: outputs changed while stalled");

   // ---------------- reference model ----------------
   function automatic logic [7:0] xtime(logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xtime(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(logic [7:0] x, int n);
      logic [15:0] d;
      d = {x, x} << n;
      return d[15:8];
   endfunction

   task automatic build_sbox;
      logic [7:0] v;
      for (int i = 0; i < 256; i++) begin
         v = 8'h01;
         for (int e = 0; e < 254; e++) v = gmul(v, 8'(i));
         sb[i] = v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3)
               ^ rotl8(v, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   task automatic expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++)
         mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic push_mk(input int m);
      exp_t e;
      int   idx;
      for (int j = 0; j < 11; j++) begin
         idx = (m == 0) ? 10 - j : j;
         e.k = mk[idx];
         e.idx = 4'(idx);
         e.last = (m == 0) ? (idx == 0) : (idx == 10);
         if (m == 0) q0.push_back(e);
         else q1.push_back(e);
      end
   endtask

   function automatic int qsize(int m);
      return (m == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t pop(int m);
      if (m == 0) return q0.pop_front();
      return q1.pop_front();
   endfunction

   task automatic chk(input string name, input logic [127:0] got,
                      input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic         pst [2];
   logic [127:0] po [2];
   logic [3:0]   pi [2];
   logic         pl [2];

   initial begin
      pst[0] = 0;
      pst[1] = 0;
   end

   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            pst[m] = 0;
         end else begin
            if (pst[m]) begin
               chk($sformatf("hold_out%0d", m), rk_out[m], po[m]);
               chk($sformatf("hold_idx%0d", m), 128'(rk_idx[m]), 128'(pi[m]));
               chk($sformatf("hold_last%0d", m), 128'(rk_last[m]), 128'(pl[m]));
            end
            pst[m] = rk_valid[m] && !rk_ready && !flush;
            po[m] = rk_out[m];
            pi[m] = rk_idx[m];
            pl[m] = rk_last[m];
            if (rk_valid[m] && rk_ready && !flush) begin
               exp_t e;
               hs[m]++;
               if (qsize(m) == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_key%0d: got idx %0d expected none",
                           m, rk_idx[m]);
               end else begin
                  e = pop(m);
                  chk($sformatf("rk_out%0d_idx%0d", m, e.idx), rk_out[m], e.k);
                  chk($sformatf("rk_idx%0d", m), 128'(rk_idx[m]), 128'(e.idx));
                  chk($sformatf("rk_last%0d_idx%0d", m, e.idx),
                      128'(rk_last[m]), 128'(e.last));
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input int m, input logic [127:0] key);
      key_in = key;
      key_valid[m] = 1;
      tick;
      key_valid[m] = 0;
   endtask

   task automatic drive(input int m, input logic [127:0] key, input bit bp,
                        output int first_v, output int done_c);
      rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      accept(m, key);
      first_v = -1;
      done_c = -1;
      for (int c = 0; c < 400; c++) begin
         if (first_v < 0 && rk_valid[m]) first_v = c;
         if (c > 0 && key_ready[m]) begin
            done_c = c;
            break;
         end
         rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         tick;
      end
      if (done_c < 0) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout%0d: got no return to idle expected within 400 cycles", m);
      end
   endtask

   task automatic drain(input int m);
      int ok = 0;
      for (int c = 0; c < 100; c++) begin
         if (key_ready[m]) begin
            ok = 1;
            break;
         end
         rk_ready = 1;
         tick;
      end
      if (ok == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout%0d: got busy expected idle", m);
      end
   endtask

   task automatic wait_idx(input int m, input logic [3:0] idx);
      int ok = 0;
      for (int c = 0; c < 40; c++) begin
         if (rk_valid[m] && rk_idx[m] == idx) begin
            ok = 1;
            break;
         end
         tick;
      end
      if (ok == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_idx%0d: got no idx %0d expected it", m, idx);
      end
   endtask

   task automatic check_idle(input string name, input int m);
      chk({name, "_valid"}, 128'(rk_valid[m]), 128'(0));
      chk({name, "_kready"}, 128'(key_ready[m]), 128'(1));
   endtask

   initial begin
      int fv, dc;
      logic [127:0] k, k6;
      key_valid[0] = 0;
      key_valid[1] = 0;
      hs[0] = 0;
      hs[1] = 0;
      build_sbox;

      // reset state
      #12;
      chk("rst_out", rk_out[0], 128'(0));
      chk("rst_idx", 128'(rk_idx[0]), 128'(0));
      chk("rst_last", 128'(rk_last[0]), 128'(0));
      check_idle("rst0", 0);
      check_idle("rst1", 1);
      @(negedge clk);
      rst = 0;
      tick;

      // descending, FIPS appendix key, known round keys
      expand(K1);
      mk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
      mk[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
      mk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
      mk[0]  = K1;
      push_mk(0);
      drive(0, K1, 0, fv, dc);
      chk("latency_desc", 128'(fv), 128'(10));
      chk("done_desc", 128'(dc), 128'(21));
      chk("drained_t1", 128'(qsize(0)), 128'(0));

      // descending, FIPS 2b7e key, handshake count
      hs[0] = 0;
      expand(K2);
      mk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      mk[0]  = K2;
      push_mk(0);
      drive(0, K2, 0, fv, dc);
      chk("hs_desc", 128'(hs[0]), 128'(11));
      chk("drained_t2", 128'(qsize(0)), 128'(0));

      // ascending, FIPS appendix key
      hs[1] = 0;
      expand(K1);
      mk[0]  = K1;
      mk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
      push_mk(1);
      drive(1, K1, 0, fv, dc);
      chk("latency_asc", 128'(fv), 128'(0));
      chk("done_asc", 128'(dc), 128'(11));
      chk("hs_asc", 128'(hs[1]), 128'(11));
      chk("drained_t3", 128'(qsize(1)), 128'(0));

      // random keys under random backpressure, both orders
      expand(K1);
      push_mk(0);
      drive(0, K1, 1, fv, dc);
      for (int n = 0; n < 4; n++) begin
         for (int m = 0; m < 2; m++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            expand(k);
            push_mk(m);
            drive(m, k, 1, fv, dc);
            chk($sformatf("drained_bp%0d", m), 128'(qsize(m)), 128'(0));
         end
      end

      // flush during precompute, then a full sequence
      rk_ready = 1;
      accept(0, {$urandom, $urandom, $urandom, $urandom});
      repeat (5) tick;
      flush = 1;
      tick;
      flush = 0;
      check_idle("flush_pre", 0);
      k = {$urandom, $urandom, $urandom, $urandom};
      expand(k);
      push_mk(0);
      drive(0, k, 0, fv, dc);
      chk("drained_fpre", 128'(qsize(0)), 128'(0));

      // flush in emit at idx 6 together with a handshake
      k = {$urandom, $urandom, $urandom, $urandom};
      expand(k);
      k6 = mk[6];
      push_mk(0);
      rk_ready = 1;
      accept(0, k);
      wait_idx(0, 4'd6);
      flush = 1;
      tick;
      flush = 0;
      check_idle("flush_emit", 0);
      chk("flush_keeps_key", rk_out[0], k6);
      q0.delete();
      k = {$urandom, $urandom, $urandom, $urandom};
      expand(k);
      push_mk(0);
      drive(0, k, 1, fv, dc);
      chk("drained_femit", 128'(qsize(0)), 128'(0));

      // key_valid while busy is ignored
      k = {$urandom, $urandom, $urandom, $urandom};
      expand(k);
      push_mk(1);
      rk_ready = 0;
      accept(1, k);
      key_in = ~k;
      key_valid[1] = 1;
      repeat (3) tick;
      chk("busy_kready", 128'(key_ready[1]), 128'(0));
      chk("busy_noreload", rk_out[1], k);
      key_valid[1] = 0;
      drain(1);
      chk("drained_busy", 128'(qsize(1)), 128'(0));

      // asynchronous reset in the middle of emit
      k = {$urandom, $urandom, $urandom, $urandom};
      expand(k);
      push_mk(0);
      rk_ready = 1;
      accept(0, k);
      wait_idx(0, 4'd8);
      rk_ready = 0;
      tick;
      #2;
      rst = 1;
      #1;
      chk("arst_out", rk_out[0], 128'(0));
      chk("arst_idx", 128'(rk_idx[0]), 128'(0));
      chk("arst_last", 128'(rk_last[0]), 128'(0));
      check_idle("arst", 0);
      q0.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      tick;
      expand(K2);
      push_mk(0);
      drive(0, K2, 0, fv, dc);
      chk("drained_arst", 128'(qsize(0)), 128'(0));

      repeat (3) tick;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/aes128_inv_key_sched.md
Name: aes128_inv_key_sched

Overview:
- Iterative AES-128 round-key generator with valid/ready handshakes on both sides.
- Default mode feeds a decryption datapath: round keys are emitted last-first (10 down to 0), derived on the fly by reversing the key schedule.
- Optional ascending mode feeds an encryption datapath (0 up to 10).
- Replaces the full 1408-bit expanded-key bus with one 128-bit key register plus one shared SubWord unit.

Parameters:
- EMIT_ORDER, 0, key emission order. 0 = descending 10..0, with forward precompute. 1 = ascending 0..10, no precompute.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort; forces IDLE next cycle
- key_in  in  128  cipher key; word0 = key_in[127:96] (FIPS-197 byte order)
- key_valid  in  1  key_in valid
- key_ready  out  1  high only in IDLE
- rk_out  out  128  current round key
- rk_idx  out  4  round number of rk_out (0..10)
- rk_last  out  1  high with the final key of the sequence (idx 0 in mode 0, idx 10 in mode 1)
- rk_valid  out  1  rk_out/rk_idx valid
- rk_ready  in  1  consumer accepts the key

Behaviour:
- Reset values: key register 0, rk_out 0, rk_idx 0, rk_valid 0, rk_last 0, key_ready 1, state IDLE, round counter 0.
- Key accept: key_valid & key_ready on a rising edge loads key_in into the key register.
  - Mode 0: load round counter 0, go to PRECOMP.
  - Mode 1: load round counter 0, go to EMIT with rk_idx 0.
- PRECOMP (mode 0 only): one forward step per cycle, ten cycles; round counter counts 1..10.
  - Forward step: w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon[r]; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - Rcon = 01,02,04,08,10,20,40,80,1B,36, placed in the MSB byte.
  - After step 10, go to EMIT with rk_idx 10.
  - Latency: key accepted at edge 0; rk_valid first high after edge 10 with rk_idx 10.
- EMIT: rk_valid = 1; rk_out = key register; rk_idx = round counter.
  - No handshake (rk_ready = 0): rk_out, rk_idx and rk_last hold stable. A bench assertion must check this.
  - Handshake (rk_valid & rk_ready) and not last: one step; rk_idx decrements (mode 0) or increments (mode 1). Next key is valid the following cycle, giving back-to-back throughput of one key per cycle.
  - Reverse step from round r to r-1: w3 = w3' ^ w2'; w2 = w2' ^ w1'; w1 = w1' ^ w0'; w0 = w0' ^ SubWord(RotWord(w3)) ^ Rcon[r-1]. The SubWord input is the newly computed w3, from the same cycle.
  - Handshake on the last key: go to IDLE; rk_valid drops and key_ready rises on the next cycle.
- rk_last is combinational from state, order and rk_idx; it is high only while rk_valid is high.
- Single SubWord instance. Its input mux selects old w3 for forward steps and computed w3 for reverse steps.
- Round counter never leaves 0..10.
- key_valid outside IDLE is ignored; the key is not queued.
- flush: has priority over every transition and any handshake in the same cycle. Next cycle is IDLE with rk_valid 0 and key_ready 1; the key register is left unchanged.
- rst asserted mid-sequence: immediately returns all outputs to their reset values, with no clock required.
- Arithmetic is XOR only, with no carries. Rcon lookup is indexed by the round counter, never by shifting.

Decomposition:
- Package aes_pkg holds:
  - SBOX constant array (256x8) and sbox function
  - RCON constant array (index 0..9)
  - state enum {IDLE, PRECOMP, EMIT}
  - order constants EMIT_DESC = 0, EMIT_ASC = 1
- One combinational sub-module, aes_subword: 32-bit in and out, four S-box lookups, RotWord applied by the caller.

Test Plan:
- Mode 0, key 000102030405060708090a0b0c0d0e0f, rk_ready held 1:
  - first rk_valid 10 cycles after accept; idx 10 = 13111d7fe3944a17f307a78b4d2b30c5, idx 9 = 549932d1f08557681093ed9cbe2c974e, idx 1 = d6aa74fdd2af72fadaa678f1d6ab76fe, idx 0 = key with rk_last 1; key_ready 1 next cycle.
- Mode 0, key 2b7e151628aed2a6abf7158809cf4f3c: idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, idx 0 = key; exactly 11 handshakes.
- Mode 1, same FIPS key: idx 0 = key on the cycle after accept; idx 10 = 13111d7f..4d2b30c5 with rk_last 1; 11 consecutive cycles with rk_ready = 1.
- Random rk_ready backpressure (about 50%): rk_out/rk_idx stable while stalled; sequence identical to the no-stall run.
- flush during PRECOMP cycle 5, and separately during EMIT at idx 6 together with rk_ready:
  - next cycle IDLE, rk_valid 0, key_ready 1;
  - a new key accepted afterwards produces the correct full sequence.
- rst asserted mid-EMIT between clock edges: outputs go to reset values immediately; key_valid asserted while not IDLE is ignored (key_ready 0, no reload).
